// File: rtl/link_rx_deframer.sv
// -----------------------------------------------------------------------------
// link_rx_deframer
//
// Receive side of the serial link. The forwarded bit clock (clkIn) and data
// line (dataIn) are synchronized into the clk domain, a bit is sampled on
// every falling edge of the synchronized bit clock, and FRAME_BITS samples are
// assembled into one parallel frame. The frame is offered on a valid/ready
// handshake. A frame that completes while the previous one is still pending
// is dropped and flagged as an overrun.
//
// Optional feature (compile-time macro LINK_RX_TIMEOUT_EN):
//   builds a stall timer that abandons a partial frame after TIMEOUT_CYCLES
//   clk cycles without a sample and raises the sticky errTimeout flag.
//   Without the macro there is no timer and no errTimeout port.
//
// Ports:
//   clk         system clock, the only clock
//   rst         asynchronous, active-low reset
//   clkIn       serial bit clock from the link (asynchronous)
//   dataIn      serial data from the link (asynchronous)
//   frame       last completed frame, bit 0 = first bit received
//   frameValid  frame holds an unaccepted frame
//   frameReady  consumer accepts frame when high together with frameValid
//   bitCount    bits captured so far in the current frame
//   busy        a frame is partially received
//   overrun     sticky: a frame completed while frameValid was not accepted
//   errTimeout  sticky: a partial frame was abandoned (timeout build only)
//   clrErr      synchronous clear of overrun / errTimeout (set wins)
// -----------------------------------------------------------------------------
module link_rx_deframer #(
  parameter int FRAME_BITS     = 256,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clkIn,
  input  logic                          dataIn,
  output logic [FRAME_BITS-1:0]         frame,
  output logic                          frameValid,
  input  logic                          frameReady,
  output logic [$clog2(FRAME_BITS):0]   bitCount,
  output logic                          busy,
  output logic                          overrun,
`ifdef LINK_RX_TIMEOUT_EN
  output logic                          errTimeout,
`endif
  input  logic                          clrErr
);

  localparam int CW = $clog2(FRAME_BITS) + 1;
  localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q,  clk_prev_d;
  state_e                 state_q,     state_d;
  logic [CW-1:0]          bit_cnt_q,   bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q,     shift_d;
  logic [FRAME_BITS-1:0]  frame_q,     frame_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   overrun_q,   overrun_d;

`ifdef LINK_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STALL_ONE  = TW'(1);

  logic [TW-1:0]          stall_q,     stall_d;
  logic                   err_timeout_q, err_timeout_d;
`endif

  logic sample;
  logic sample_bit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], clkIn};
    data_sync_d   = {data_sync_q[SYNC_STAGES-2:0], dataIn};
    clk_prev_d    = clk_sync_q[SYNC_STAGES-1];
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;

    // Falling edge of the synchronized bit clock. Data went through a
    // synchronizer of the same depth, so it is aligned with the edge.
    sample     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    sample_bit = data_sync_q[SYNC_STAGES-1];

    // Clear first so that a same-cycle error set below overrides it.
    if (clrErr) begin
      overrun_d = 1'b0;
    end

    if (frame_valid_q && frameReady) begin
      frame_valid_d = 1'b0;
    end

    if (sample) begin
      shift_d[bit_cnt_q[IW-1:0]] = sample_bit;
      if (bit_cnt_q == LAST_BIT) begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        // An accept in this same cycle frees the output register, so the new
        // frame can load without an overrun.
        if (!frame_valid_q || frameReady) begin
          frame_d       = shift_d;
          frame_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        state_d   = S_RECV;
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
    end

`ifdef LINK_RX_TIMEOUT_EN
    stall_d       = '0;
    err_timeout_d = err_timeout_q;
    if (clrErr) begin
      err_timeout_d = 1'b0;
    end
    // The timer only runs between samples of a partial frame.
    if (state_q == S_RECV && !sample) begin
      if (stall_q == STALL_LAST) begin
        state_d       = S_IDLE;
        bit_cnt_d     = '0;
        err_timeout_d = 1'b1;
      end else begin
        stall_d = stall_q + STALL_ONE;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q    <= '0;
      data_sync_q   <= '0;
      clk_prev_q    <= 1'b0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      // NOTE: the shift register is wide but still reset; a reset must leave
      // no trace of a partial frame anywhere in the block.
      shift_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef LINK_RX_TIMEOUT_EN
      stall_q       <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every flop updates from the
      // values present before the edge regardless of statement order.
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
`ifdef LINK_RX_TIMEOUT_EN
      stall_q       <= stall_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign frame      = frame_q;
  assign frameValid = frame_valid_q;
  assign bitCount   = bit_cnt_q;
  assign busy       = (state_q == S_RECV);
  assign overrun    = overrun_q;
`ifdef LINK_RX_TIMEOUT_EN
  assign errTimeout = err_timeout_q;
`endif

endmodule

// File: tb/tb_link_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_link_rx_deframer
//
// Self-checking bench for link_rx_deframer with default parameters. Frames
// are driven as a bit clock with data changing on the rising edge. Every
// handshake the DUT completes is logged by a monitor and compared against
// the frames the bench itself sent.
// -----------------------------------------------------------------------------
module tb_link_rx_deframer;

  localparam int FB = 256;

  logic          clk;
  logic          rst;
  logic          clk_in;
  logic          data_in;
  logic [FB-1:0] frame;
  logic          frame_valid;
  logic          frame_ready;
  logic [8:0]    bit_count;
  logic          busy;
  logic          overrun;
  logic          clr_err;
`ifdef LINK_RX_TIMEOUT_EN
  logic          err_timeout;
`endif

  link_rx_deframer #(
    .FRAME_BITS    (FB),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkIn     (clk_in),
    .dataIn    (data_in),
    .frame     (frame),
    .frameValid(frame_valid),
    .frameReady(frame_ready),
    .bitCount  (bit_count),
    .busy      (busy),
    .overrun   (overrun),
`ifdef LINK_RX_TIMEOUT_EN
    .errTimeout(err_timeout),
`endif
    .clrErr    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [FB-1:0] acc_q[$];   // frames the DUT handed over, in order
  logic [FB-1:0] exp_q[$];   // frames the bench expects, in order
  bit            rand_ready_en = 1'b0;

  typedef struct {
    logic [FB-1:0] data;
    bit            ready;
    logic [FB-1:0] exp_frame;
    bit            exp_valid;
    bit            exp_overrun;
    int            exp_acc;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [FB-1:0] got,
                       input logic [FB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Handshake monitor, sampled 1 ns after the falling clk edge.
  always @(negedge clk) begin
    #1;
    if (rst && frame_valid && frame_ready) acc_q.push_back(frame);
  end

  // Random backpressure driver.
  always @(negedge clk) begin
    if (rand_ready_en) frame_ready = 1'($urandom_range(0, 1));
  end

  // One bit: data changes with the rising bit clock, sampled at the fall.
  task automatic send_bit(input bit b, input int hi, input int lo);
    data_in = b;
    clk_in  = 1'b1;
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Whole frame, bit 0 first. With pulse set, frameReady is raised for
  // exactly the cycle in which the final falling edge is detected.
  task automatic send_frame(input logic [FB-1:0] d, input bit pulse,
                            input bit rnd);
    int hi;
    int lo;
    for (int i = 0; i < FB; i++) begin
      hi = rnd ? int'($urandom_range(4, 6)) : 4;
      lo = rnd ? int'($urandom_range(4, 6)) : 4;
      if (pulse && i == FB - 1) begin
        data_in = d[i];
        clk_in  = 1'b1;
        repeat (hi) @(negedge clk);
        clk_in = 1'b0;
        repeat (2) @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        @(negedge clk);
      end else begin
        send_bit(d[i], hi, lo);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB-1:0] pat_a;
    logic [FB-1:0] one_hot;
    logic [FB-1:0] d;
    int            n_rand;

    pat_a   = {32{8'h55}};
    one_hot = (256'd1 << 255) | 256'd1;
    n_rand  = 5;

    vecs[0] = '{one_hot,  1'b1, one_hot, 1'b0, 1'b0, 1};
    vecs[1] = '{'1,       1'b1, '1,      1'b0, 1'b0, 1};
    vecs[2] = '{pat_a,    1'b0, pat_a,   1'b1, 1'b0, 0};
    vecs[3] = '{~pat_a,   1'b0, pat_a,   1'b1, 1'b1, 0};

    rst         = 1'b0;
    clk_in      = 1'b0;
    data_in     = 1'b0;
    frame_ready = 1'b0;
    clr_err     = 1'b0;

    // ---------------- reset with the bit clock toggling ----------------
    repeat (3) begin
      @(negedge clk);
      clk_in  = ~clk_in;
      data_in = ~data_in;
    end
    check("rst frame",   frame,       '0);
    check("rst valid",   frame_valid, 0);
    check("rst bitcnt",  bit_count,   0);
    check("rst busy",    busy,        0);
    check("rst overrun", overrun,     0);
`ifdef LINK_RX_TIMEOUT_EN
    check("rst errtimeout", err_timeout, 0);
`endif
    clk_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post-rst bitcnt", bit_count, 0);
    check("post-rst busy",   busy,      0);

    // ---------------- table-driven frames ----------------
    for (int i = 0; i < 4; i++) begin
      frame_ready = vecs[i].ready;
      send_frame(vecs[i].data, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d frame", i),   frame,       vecs[i].exp_frame);
      check($sformatf("vec%0d valid", i),   frame_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d overrun", i), overrun,     vecs[i].exp_overrun);
      check($sformatf("vec%0d bitcnt", i),  bit_count,   0);
      check($sformatf("vec%0d busy", i),    busy,        0);
      check($sformatf("vec%0d accepts", i), acc_q.size(), vecs[i].exp_acc);
      if (vecs[i].exp_acc > 0 && acc_q.size() > 0)
        check($sformatf("vec%0d accepted data", i), acc_q.pop_front(),
              vecs[i].data);
    end

    // ---------------- clrErr clears overrun, pending frame kept ----------
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("clr overrun", overrun,     0);
    check("clr valid",   frame_valid, 1);
    check("clr frame",   frame,       pat_a);

    // ---------------- accept exactly on the completion cycle -------------
    frame_ready = 1'b0;
    send_frame(~pat_a, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("aoc frame",   frame,        ~pat_a);
    check("aoc valid",   frame_valid,  1);
    check("aoc overrun", overrun,      0);
    check("aoc accepts", acc_q.size(), 1);
    if (acc_q.size() > 0) check("aoc accepted A", acc_q.pop_front(), pat_a);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("aoc drain valid", frame_valid,  0);
    check("aoc drain count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("aoc accepted B", acc_q.pop_front(), ~pat_a);

    // ---------------- random frames, jittered phases, random ready -------
    rand_ready_en = 1'b1;
    for (int k = 0; k < n_rand; k++) begin
      for (int w = 0; w < FB / 32; w++) d[w*32 +: 32] = $urandom();
      exp_q.push_back(d);
      send_frame(d, 1'b0, 1'b1);
    end
    for (int t = 0; t < 200 && acc_q.size() < n_rand; t++) @(negedge clk);
    rand_ready_en = 1'b0;
    frame_ready   = 1'b0;
    @(negedge clk);
    check("rand accepts", acc_q.size(), n_rand);
    for (int k = 0; k < n_rand; k++) begin
      if (acc_q.size() > 0 && exp_q.size() > 0)
        check($sformatf("rand frame%0d", k), acc_q.pop_front(),
              exp_q.pop_front());
    end
    check("rand overrun", overrun, 0);
    check("rand busy",    busy,    0);

`ifdef LINK_RX_TIMEOUT_EN
    // ---------------- stall timeout ----------------
    frame_ready = 1'b1;
    for (int i = 0; i < 100; i++) send_bit(1'(i % 3 == 0), 4, 4);
    check("to bitcnt before", bit_count, 100);
    check("to busy before",   busy,      1);
    repeat (70) @(negedge clk);
    check("to errtimeout", err_timeout, 1);
    check("to bitcnt",     bit_count,   0);
    check("to busy",       busy,        0);
    check("to no accept",  acc_q.size(), 0);
    for (int w = 0; w < FB / 32; w++) d[w*32 +: 32] = $urandom();
    send_frame(d, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("to next accepts", acc_q.size(), 1);
    if (acc_q.size() > 0) check("to next frame", acc_q.pop_front(), d);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("to clr errtimeout", err_timeout, 0);
`endif

    // ---------------- reset mid-frame ----------------
    frame_ready = 1'b1;
    for (int i = 0; i < 120; i++) send_bit(1'(i % 2), 4, 4);
    check("mid bitcnt before", bit_count, 120);
    rst = 1'b0;
    @(negedge clk);
    check("mid bitcnt", bit_count,   0);
    check("mid busy",   busy,        0);
    check("mid frame",  frame,       '0);
    check("mid valid",  frame_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid overrun", overrun, 0);
`ifdef LINK_RX_TIMEOUT_EN
    check("mid errtimeout", err_timeout, 0);
`endif
    for (int w = 0; w < FB / 32; w++) d[w*32 +: 32] = $urandom();
    send_frame(d, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("mid next accepts", acc_q.size(), 1);
    if (acc_q.size() > 0) check("mid next frame", acc_q.pop_front(), d);
    check("mid next frame reg", frame, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_rx_deframer.md
# link_rx_deframer

Serial-link receive stage, downstream of the 256-bit serial comms transmitter. It samples the transmitter's forwarded bit clock and data line in the local system clock domain and reassembles each burst of bits into a parallel frame. Each completed frame is presented on a valid/ready handshake to the consuming logic, and the block reports overrun and stall errors. All logic runs on `clk`; the link signals are treated as asynchronous inputs.

## Interface
- `FRAME_BITS`, default 256: bits per frame.
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers, minimum 2.
- `TIMEOUT_CYCLES`, default 64: number of `clk` cycles without a sampled bit before a partial frame is abandoned.

- `clk`: in, 1: system clock, the only clock.
- `rst`: in, 1: reset, asynchronous and active-low.
- `clkIn`: in, 1: serial bit clock from the link, asynchronous.
- `dataIn`: in, 1: serial data from the link, asynchronous.
- `frame`: out, FRAME_BITS: last completed frame. Bit 0 is the first bit received.
- `frameValid`: out, 1: `frame` holds an unaccepted frame.
- `frameReady`: in, 1: consumer accepts `frame` when it is high in the same cycle as `frameValid`.
- `bitCount`: out, $clog2(FRAME_BITS)+1: bits captured so far in the current frame.
- `busy`: out, 1: a frame is partially received.
- `overrun`: out, 1: sticky. A frame completed while `frameValid` was held and not accepted.
- `errTimeout`: out, 1: sticky. A partial frame was abandoned by the stall timer. Exists only with the timeout feature.
- `clrErr`: in, 1: synchronous clear of `overrun` and `errTimeout`.

## Operation
- **Synchronizers.** `clkIn` and `dataIn` each pass through a SYNC_STAGES flip-flop synchronizer of equal depth. One further register on the synchronized `clkIn` provides edge detection.
- **Sampling.** A bit is sampled on a detected falling edge of synchronized `clkIn`. The transmitter changes data on the rising edge, so data is mid-bit at the falling edge. Rising edges are ignored.
- **Shift register.** The shift register is separate from the `frame` output register. Sample n goes to bit n. `bitCount` increments once per sample.
- **FSM states:**
  - IDLE: `bitCount`=0 and `busy`=0. The first sample moves the FSM to RECV.
  - RECV: `busy`=1. The FRAME_BITS-th sample completes the frame, returns the FSM to IDLE and clears `bitCount` to 0 in the same edge.
- **Frame completion, output empty:** the shift register is copied to `frame` and `frameValid` is set.
  - An accept in the same cycle as a completion counts as empty: the new frame loads and `overrun` stays 0.
- **Frame completion, output full and not accepted:** the new frame is dropped, `frame` is unchanged and `overrun` is set.
- **Acceptance:** `frameValid` && `frameReady` clears `frameValid` on the next edge. `frame` keeps its last value.
- **Simultaneous events:** a sample and `clrErr` in the same cycle is legal; the sample proceeds normally. A `clrErr` and an error-setting event in the same cycle resolve to set; the error wins.
- **Reset:** `rst` low clears every register immediately, including mid-frame. A partial frame is discarded with no error flagged.
  - Reset values: `frame`=0, `frameValid`=0, `bitCount`=0, `busy`=0, `overrun`=0, `errTimeout`=0.

## Timing
- **Sample latency:** a falling edge of `clkIn` at the pin is detected SYNC_STAGES+1 `clk` edges later. `dataIn` is captured in the same cycle it is detected.
- **Completion latency:** `frame` and `frameValid` update on the `clk` edge that registers the FRAME_BITS-th sample. `bitCount` reads 0 from that edge on.
- **Minimum `clkIn` phase:** each high and low phase must last at least SYNC_STAGES+1 `clk` cycles. The transmitter's divide-by-8 clock gives 4 cycles per phase, which meets this for the default SYNC_STAGES.
- **Stall timer:** counts `clk` cycles in RECV and resets to 0 on each sample.
- **Acceptance:** a zero-latency `frameReady` handshake sustains back-to-back frames with no bubbles.

## Configuration
- **`LINK_RX_TIMEOUT_EN` defined:**
  - The stall timer is built.
  - When the timer reaches TIMEOUT_CYCLES in RECV, the partial frame is discarded, `bitCount` goes to 0, the FSM returns to IDLE and `errTimeout` is set.
  - `errTimeout` is a port.
- **`LINK_RX_TIMEOUT_EN` not defined:**
  - No timer and no `errTimeout` port.
  - A partial frame persists until the remaining bits arrive or `rst` is asserted.

## Test plan
- **Reset values:** hold `rst` low for 3 cycles with `clkIn` toggling → all outputs at their reset values, and no sample occurs while reset is asserted.
- **Single frame:** `frameReady`=1, send (1<<255)|1 with `clkIn` at 4 `clk` high / 4 `clk` low → exactly one `frameValid` pulse with `frame`=(1<<255)|1 and `overrun`=0.
- **Backpressure:** `frameReady`=0, send frame A=alternating 0x55 pattern then frame B=~A → `frame`=A and `overrun`=1. Then assert `clrErr` → `overrun`=0.
- **Accept on completion:** raise `frameReady` for one cycle exactly on the cycle frame B completes while A is pending → `frame`=B, `frameValid`=1, `overrun`=0.
- **Stall timeout** (`LINK_RX_TIMEOUT_EN`): stop `clkIn` after 100 bits for 70 cycles → `errTimeout`=1 and `bitCount`=0. A following full frame is then received correctly.
- **Reset mid-frame:** assert `rst` at bit 120 → `bitCount`=0 and `busy`=0. The next full frame is received bit-exact.
